// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Second pipeline stage of the RV64I core. Takes one raw instruction per
// handshake from fetch (together with its pc+4), decodes register indices,
// functs, the sign-extended immediate, the instruction format and the class
// flags, and holds the result in an output register for execute.
//
// A zero word or an instruction whose opcode does not map to a known format
// halts the stage. Only a reset brings it back. A branch flush drops both the
// held instruction and the instruction that fetch is currently presenting.
//
// Ports
//   clk                  clock, all state updates on posedge
//   reset                synchronous, active-low
//   in_valid             fetch presents an instruction
//   in_instruction_bits  raw 32-bit instruction
//   in_pcplus1           address of the instruction + 4
//   in_flush             branch taken: discard held and incoming instruction
//   in_enable            execute consumes out_* this cycle
//   out_accept           decode takes in_* this cycle
//   out_valid            out_* hold a decoded instruction
//   out_pc               in_pcplus1 - 4
//   out_opcode/rd/rs1/rs2/funct3/funct7   raw instruction fields
//   out_imm              sign-extended immediate
//   out_format           R=0 I=1 S=2 B=3 U=4 J=5 invalid=7
//   out_reg_write        instruction writes a non-zero rd
//   out_is_branch/jump/load/store         class flags
//   out_halt             stage halted
//   out_decode_count     instructions decoded since reset (wraps)
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int ADDRESS_WIDTH     = 64,
    parameter int REGISTER_WIDTH    = 64,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] in_instruction_bits,
    input  logic [ADDRESS_WIDTH-1:0]     in_pcplus1,
    input  logic                         in_flush,
    input  logic                         in_enable,
    output logic                         out_accept,
    output logic                         out_valid,
    output logic [ADDRESS_WIDTH-1:0]     out_pc,
    output logic [6:0]                   out_opcode,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [2:0]                   out_funct3,
    output logic [6:0]                   out_funct7,
    output logic [REGISTER_WIDTH-1:0]    out_imm,
    output logic [2:0]                   out_format,
    output logic                         out_reg_write,
    output logic                         out_is_branch,
    output logic                         out_is_jump,
    output logic                         out_is_load,
    output logic                         out_is_store,
    output logic                         out_halt,
    output logic [63:0]                  out_decode_count
);

    // Major opcodes
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_OPIMM    = 7'b0010011;
    localparam logic [6:0] OP_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISCMEM  = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd7
    } fmt_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0]  pc;
        logic [6:0]                opcode;
        logic [4:0]                rd;
        logic [4:0]                rs1;
        logic [4:0]                rs2;
        logic [2:0]                funct3;
        logic [6:0]                funct7;
        logic [REGISTER_WIDTH-1:0] imm;
        logic [2:0]                format;
        logic                      reg_write;
        logic                      is_branch;
        logic                      is_jump;
        logic                      is_load;
        logic                      is_store;
    } dec_t;

    // Map a major opcode onto its encoding format.
    function automatic fmt_t decode_format(input logic [6:0] opcode);
        fmt_t fmt;
        case (opcode)
            OP_LUI, OP_AUIPC:                          fmt = FMT_U;
            OP_JAL:                                    fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_OPIMM, OP_OPIMM32,
            OP_SYSTEM, OP_MISCMEM:                     fmt = FMT_I;
            OP_STORE:                                  fmt = FMT_S;
            OP_BRANCH:                                 fmt = FMT_B;
            OP_OP, OP_OP32:                            fmt = FMT_R;
            default:                                   fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

    // Gather the scattered immediate bits into a 32-bit signed value, then
    // widen; the signed cast carries inst[31] into the upper bits.
    function automatic logic signed [REGISTER_WIDTH-1:0] build_imm(
        input logic [31:0] inst,
        input fmt_t        fmt
    );
        logic signed [31:0] imm32;
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
            FMT_U: imm32 = {inst[31:12], 12'b0};
            FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        return REGISTER_WIDTH'(imm32);
    endfunction

    logic [31:0] inst;
    fmt_t        fmt_p0;
    dec_t        dec_p0;
    dec_t        dec_p1;
    logic        valid_p1;
    logic [63:0] count_p1;
    state_t      state;
    state_t      state_next;
    logic        handshake;
    logic        illegal;
    logic        load_en;

    assign inst = in_instruction_bits[31:0];

    // ---- stage p0: combinational decode of the incoming word ----
    always_comb begin
        fmt_p0           = decode_format(inst[6:0]);
        dec_p0           = '0;
        dec_p0.pc        = in_pcplus1 - ADDRESS_WIDTH'(4);
        dec_p0.opcode    = inst[6:0];
        dec_p0.rd        = inst[11:7];
        dec_p0.rs1       = inst[19:15];
        dec_p0.rs2       = inst[24:20];
        dec_p0.funct3    = inst[14:12];
        dec_p0.funct7    = inst[31:25];
        dec_p0.imm       = build_imm(inst, fmt_p0);
        dec_p0.format    = fmt_p0;
        dec_p0.reg_write = (fmt_p0 inside {FMT_R, FMT_I, FMT_U, FMT_J}) &&
                           (inst[11:7] != 5'd0);
        dec_p0.is_branch = (inst[6:0] == OP_BRANCH);
        dec_p0.is_jump   = (inst[6:0] == OP_JAL) || (inst[6:0] == OP_JALR);
        dec_p0.is_load   = (inst[6:0] == OP_LOAD);
        dec_p0.is_store  = (inst[6:0] == OP_STORE);
    end

    // The output register can take a new word when it is empty or when
    // execute is draining it in the same cycle.
    assign out_accept = (state == ST_RUN) && (!valid_p1 || in_enable);
    // Flush outranks a handshake: the incoming word is simply dropped.
    assign handshake  = in_valid && out_accept && !in_flush;
    assign illegal    = (inst == 32'd0) || (fmt_p0 == FMT_BAD);
    assign load_en    = handshake && !illegal;

    // ---- control FSM ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_halt   = 1'b0;
        case (state)
            ST_RUN: begin
                if (handshake && illegal) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                out_halt = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // ---- stage p1: output register toward execute ----
    // A halting word, a flush, or a drain without replacement all leave the
    // register empty; the field contents are left as they were.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_p1 <= 1'b0;
            count_p1 <= 64'd0;
            dec_p1   <= '0;
        end else if (state == ST_RUN) begin
            if (load_en) begin
                dec_p1   <= dec_p0;
                valid_p1 <= 1'b1;
                count_p1 <= count_p1 + 64'd1;
            end else if (in_flush || in_enable || handshake) begin
                valid_p1 <= 1'b0;
            end
        end
    end

    assign out_valid        = valid_p1;
    assign out_pc           = dec_p1.pc;
    assign out_opcode       = dec_p1.opcode;
    assign out_rd           = dec_p1.rd;
    assign out_rs1          = dec_p1.rs1;
    assign out_rs2          = dec_p1.rs2;
    assign out_funct3       = dec_p1.funct3;
    assign out_funct7       = dec_p1.funct7;
    assign out_imm          = dec_p1.imm;
    assign out_format       = dec_p1.format;
    assign out_reg_write    = dec_p1.reg_write;
    assign out_is_branch    = dec_p1.is_branch;
    assign out_is_jump      = dec_p1.is_jump;
    assign out_is_load      = dec_p1.is_load;
    assign out_is_store     = dec_p1.is_store;
    assign out_decode_count = count_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed cases with literal expectations plus a
// randomized run, all checked against a behavioural model of the stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instruction_bits = 32'd0;
    logic [63:0] in_pcplus1 = 64'd0;
    logic        in_flush = 1'b0;
    logic        in_enable = 1'b0;

    logic        out_accept, out_valid;
    logic [63:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [63:0] out_imm;
    logic [2:0]  out_format;
    logic        out_reg_write, out_is_branch, out_is_jump, out_is_load, out_is_store;
    logic        out_halt;
    logic [63:0] out_decode_count;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    decode_stage #(
        .ADDRESS_WIDTH(64),
        .REGISTER_WIDTH(64),
        .INSTRUCTION_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_instruction_bits(in_instruction_bits),
        .in_pcplus1(in_pcplus1),
        .in_flush(in_flush),
        .in_enable(in_enable),
        .out_accept(out_accept),
        .out_valid(out_valid),
        .out_pc(out_pc),
        .out_opcode(out_opcode),
        .out_rd(out_rd),
        .out_rs1(out_rs1),
        .out_rs2(out_rs2),
        .out_funct3(out_funct3),
        .out_funct7(out_funct7),
        .out_imm(out_imm),
        .out_format(out_format),
        .out_reg_write(out_reg_write),
        .out_is_branch(out_is_branch),
        .out_is_jump(out_is_jump),
        .out_is_load(out_is_load),
        .out_is_store(out_is_store),
        .out_halt(out_halt),
        .out_decode_count(out_decode_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_format(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111:                         return 3'd4;
            7'b1101111:                                     return 3'd5;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0011011,
            7'b1110011, 7'b0001111:                         return 3'd1;
            7'b0100011:                                     return 3'd2;
            7'b1100011:                                     return 3'd3;
            7'b0110011, 7'b0111011:                         return 3'd0;
            default:                                        return 3'd7;
        endcase
    endfunction

    // Interpret a w-bit two's complement number held in raw.
    function automatic logic [63:0] sext(input longint unsigned raw, input int w);
        longint v;
        v = longint'(raw);
        if (((raw >> (w - 1)) & 64'd1) != 0) v = v - (longint'(1) << w);
        return 64'(v);
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        longint unsigned raw;
        case (ref_format(i[6:0]))
            3'd1: return sext(longint'(i[31:20]), 12);
            3'd2: begin
                raw = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                return sext(raw, 12);
            end
            3'd3: begin
                raw = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                      longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                return sext(raw, 13);
            end
            3'd4: return sext(longint'(i[31:12]) * 4096, 32);
            3'd5: begin
                raw = longint'(i[31]) * (64'd1 << 20) + longint'(i[19:12]) * 4096 +
                      longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                return sext(raw, 21);
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_reg_write(input logic [31:0] i);
        logic [2:0] f;
        f = ref_format(i[6:0]);
        return (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5) && (i[11:7] != 5'd0);
    endfunction

    logic        m_valid, m_halt;
    logic [63:0] m_count, m_pc;
    logic [31:0] m_inst;

    always @(posedge clk) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_halt  <= 1'b0;
            m_count <= 64'd0;
        end else if (!m_halt) begin
            if (in_flush) begin
                m_valid <= 1'b0;
            end else if (in_valid && (!m_valid || in_enable)) begin
                if (in_instruction_bits == 32'd0 || ref_format(in_instruction_bits[6:0]) == 3'd7) begin
                    m_halt  <= 1'b1;
                    m_valid <= 1'b0;
                end else begin
                    m_valid <= 1'b1;
                    m_inst  <= in_instruction_bits;
                    m_pc    <= in_pcplus1 - 64'd4;
                    m_count <= m_count + 64'd1;
                end
            end else if (in_enable) begin
                m_valid <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("valid", out_valid, m_valid);
            chk("halt", out_halt, m_halt);
            chk("accept", out_accept, !m_halt && (!m_valid || in_enable));
            chk("count", out_decode_count, m_count);
            if (m_valid) begin
                chk("pc", out_pc, m_pc);
                chk("opcode", out_opcode, m_inst[6:0]);
                chk("rd", out_rd, m_inst[11:7]);
                chk("rs1", out_rs1, m_inst[19:15]);
                chk("rs2", out_rs2, m_inst[24:20]);
                chk("funct3", out_funct3, m_inst[14:12]);
                chk("funct7", out_funct7, m_inst[31:25]);
                chk("imm", out_imm, ref_imm(m_inst));
                chk("format", out_format, ref_format(m_inst[6:0]));
                chk("reg_write", out_reg_write, ref_reg_write(m_inst));
                chk("is_branch", out_is_branch, m_inst[6:0] == 7'b1100011);
                chk("is_jump", out_is_jump, m_inst[6:0] == 7'b1101111 || m_inst[6:0] == 7'b1100111);
                chk("is_load", out_is_load, m_inst[6:0] == 7'b0000011);
                chk("is_store", out_is_store, m_inst[6:0] == 7'b0100011);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] p,
                         input logic f, input logic e);
        in_valid = v;
        in_instruction_bits = i;
        in_pcplus1 = p;
        in_flush = f;
        in_enable = e;
    endtask

    logic [6:0] ops [13] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                             7'b0000011, 7'b0010011, 7'b0011011, 7'b1110011,
                             7'b0001111, 7'b0100011, 7'b1100011, 7'b0110011,
                             7'b0111011};

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = $urandom_range(0, 99);
        if (sel == 0) return 32'd0;
        if (sel == 1) return {r[31:7], 7'b1111111};
        return {r[31:7], ops[$urandom_range(0, 12)]};
    endfunction

    initial begin
        // Reset held for two edges while fetch presents a word: nothing decodes.
        drive(1'b1, 32'h00500093, 64'h104, 1'b0, 1'b1);
        reset = 1'b0;
        tick();
        cmp_on = 1'b1;
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_halt", out_halt, 1'b0);
        chk("rst_count", out_decode_count, 64'd0);
        chk("rst_imm", out_imm, 64'd0);
        chk("rst_format", out_format, 3'd0);
        chk("rst_rd", out_rd, 5'd0);
        chk("rst_pc", out_pc, 64'd0);

        // addi x1,x0,5
        reset = 1'b1;
        tick();
        chk("addi_valid", out_valid, 1'b1);
        chk("addi_pc", out_pc, 64'h100);
        chk("addi_format", out_format, 3'd1);
        chk("addi_rd", out_rd, 5'd1);
        chk("addi_rs1", out_rs1, 5'd0);
        chk("addi_imm", out_imm, 64'd5);
        chk("addi_regw", out_reg_write, 1'b1);
        chk("addi_count", out_decode_count, 64'd1);

        // sw x2,8(x1)
        drive(1'b1, 32'h0020A423, 64'h108, 1'b0, 1'b1);
        tick();
        chk("sw_format", out_format, 3'd2);
        chk("sw_rs1", out_rs1, 5'd1);
        chk("sw_rs2", out_rs2, 5'd2);
        chk("sw_imm", out_imm, 64'd8);
        chk("sw_store", out_is_store, 1'b1);
        chk("sw_regw", out_reg_write, 1'b0);

        // beq x0,x0,-4
        drive(1'b1, 32'hFE000EE3, 64'h10C, 1'b0, 1'b1);
        tick();
        chk("beq_format", out_format, 3'd3);
        chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_branch", out_is_branch, 1'b1);

        // lui x5,0x80000
        drive(1'b1, 32'h800002B7, 64'h110, 1'b0, 1'b1);
        tick();
        chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_rd", out_rd, 5'd5);

        // pc wrap: in_pcplus1 = 0
        drive(1'b1, 32'h00500093, 64'h0, 1'b0, 1'b1);
        tick();
        chk("pcwrap_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("pcwrap_count", out_decode_count, 64'd5);

        // Backpressure: addi x3,x0,10 waits three cycles.
        drive(1'b1, 32'h00A00193, 64'h200, 1'b0, 1'b0);
        #1;
        chk("stall_accept", out_accept, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_accept_k", out_accept, 1'b0);
            chk("stall_rd", out_rd, 5'd1);
            chk("stall_count", out_decode_count, 64'd5);
            chk("stall_valid", out_valid, 1'b1);
        end
        in_enable = 1'b1;
        #1;
        chk("resume_accept", out_accept, 1'b1);
        tick();
        chk("resume_rd", out_rd, 5'd3);
        chk("resume_imm", out_imm, 64'd10);
        chk("resume_pc", out_pc, 64'h1FC);
        chk("resume_count", out_decode_count, 64'd6);

        // Flush beats handshake and enable.
        drive(1'b1, 32'h00400213, 64'h300, 1'b1, 1'b1);
        tick();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_count", out_decode_count, 64'd6);
        in_flush = 1'b0;
        tick();
        chk("postflush_valid", out_valid, 1'b1);
        chk("postflush_rd", out_rd, 5'd4);
        chk("postflush_count", out_decode_count, 64'd7);

        // Halt on zero word; flush and valid words have no effect afterward.
        drive(1'b1, 32'h00000000, 64'h400, 1'b0, 1'b1);
        tick();
        chk("halt0_halt", out_halt, 1'b1);
        chk("halt0_valid", out_valid, 1'b0);
        chk("halt0_accept", out_accept, 1'b0);
        chk("halt0_count", out_decode_count, 64'd7);
        drive(1'b1, 32'h00500093, 64'h404, 1'b1, 1'b1);
        tick();
        in_flush = 1'b0;
        tick();
        chk("halted_halt", out_halt, 1'b1);
        chk("halted_valid", out_valid, 1'b0);
        chk("halted_count", out_decode_count, 64'd7);
        reset = 1'b0;
        tick();
        chk("unhalt_halt", out_halt, 1'b0);
        chk("unhalt_count", out_decode_count, 64'd0);
        reset = 1'b1;

        // Halt on an invalid opcode.
        drive(1'b1, 32'hFFFFFFFF, 64'h500, 1'b0, 1'b1);
        tick();
        chk("haltff_halt", out_halt, 1'b1);
        chk("haltff_accept", out_accept, 1'b0);
        drive(1'b1, 32'h00500093, 64'h504, 1'b0, 1'b1);
        tick();
        chk("haltff_valid", out_valid, 1'b0);
        chk("haltff_count", out_decode_count, 64'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // Randomized traffic, checked by the per-cycle compare.
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] hi;
            logic [31:0] lo;
            hi = $urandom;
            lo = $urandom;
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            drive($urandom_range(0, 3) != 0, rand_inst(), {hi, lo},
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
            tick();
        end

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
